// File: rtl/pe_router.sv
// N-port router between FWFT input FIFOs and output FIFOs with selectable routing map,
// one holding register per output, drain-before-switch mode changes and per-output counters.
module pe_router #(
    parameter int DATA_WIDTH = 128,
    parameter int NPORTS     = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    output logic [NPORTS-1:0]            rd,
    input  logic [NPORTS-1:0]            vld,
    input  logic [NPORTS*DATA_WIDTH-1:0] dout,
    output logic [NPORTS-1:0]            wr,
    input  logic [NPORTS-1:0]            full,
    output logic [NPORTS*DATA_WIDTH-1:0] din,
    output logic [1:0]                   cur_mode,
    output logic                         busy,
    output logic [NPORTS*CNT_WIDTH-1:0]  xfer_cnt
);
    // mode_q | meaning
    // 0      | PAIR_SWAP: output j fed by input j^1
    // 1      | LOOPBACK:  output j fed by input j
    // 2      | ROTATE:    output j fed by input j-1 (mod NPORTS)
    // 3      | HOLD:      no loads, registers drain and idle
    localparam int         IW        = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [1:0] PAIR_SWAP = 2'd0;
    localparam logic [1:0] LOOPBACK  = 2'd1;
    localparam logic [1:0] ROTATE    = 2'd2;
    localparam logic [1:0] HOLD      = 2'd3;

    logic [1:0]            mode_q;
    logic [1:0]            mode_d;
    logic                  pend;
    logic [NPORTS-1:0]     out_vld;
    logic [DATA_WIDTH-1:0] out_data [NPORTS];
    logic [CNT_WIDTH-1:0]  cnt      [NPORTS];
    logic [DATA_WIDTH-1:0] in_word  [NPORTS];
    logic [IW-1:0]         src      [NPORTS];
    logic [IW-1:0]         dst      [NPORTS];
    logic [NPORTS-1:0]     load;
    logic [NPORTS-1:0]     wr_i;

    always_ff @(posedge clk) begin
        if (rst) mode_q <= PAIR_SWAP;
        else     mode_q <= mode_d;
    end

    // A new mode is adopted only once every holding register has drained.
    always_comb begin
        mode_d = mode_q;
        if (pend && (out_vld == '0)) mode_d = mode;
    end

    always_comb begin
        pend     = (mode != mode_q);
        cur_mode = mode_q;
        busy     = (|out_vld) | pend;
    end

    // src: input feeding output j; dst: output fed by input j (inverse map).
    always_comb begin
        for (int j = 0; j < NPORTS; j++) begin
            case (mode_q)
                PAIR_SWAP: begin
                    src[j] = IW'(j ^ 1);
                    dst[j] = IW'(j ^ 1);
                end
                ROTATE: begin
                    src[j] = IW'((j + NPORTS - 1) % NPORTS);
                    dst[j] = IW'((j + 1) % NPORTS);
                end
                default: begin
                    src[j] = IW'(j);
                    dst[j] = IW'(j);
                end
            endcase
        end
    end

    // Reset gates both strobes so held words are dropped and nothing is popped.
    always_comb begin
        for (int j = 0; j < NPORTS; j++) begin
            in_word[j] = dout[j*DATA_WIDTH +: DATA_WIDTH];
            wr_i[j]    = out_vld[j] & ~full[j] & ~rst;
            load[j]    = vld[src[j]] & (~out_vld[j] | wr_i[j]) & ~pend
                         & (mode_q != HOLD) & ~rst;
        end
    end

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            rd[i] = load[dst[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= '0;
            for (int j = 0; j < NPORTS; j++) begin
                out_data[j] <= '0;
                cnt[j]      <= '0;
            end
        end else begin
            for (int j = 0; j < NPORTS; j++) begin
                if (load[j]) begin
                    out_data[j] <= in_word[src[j]];
                    out_vld[j]  <= 1'b1;
                end else if (wr_i[j]) begin
                    out_vld[j]  <= 1'b0;
                end
                if (wr_i[j]) cnt[j] <= cnt[j] + 1'b1;
            end
        end
    end

    always_comb begin
        wr = wr_i;
        for (int j = 0; j < NPORTS; j++) begin
            din[j*DATA_WIDTH +: DATA_WIDTH]  = out_data[j];
            xfer_cnt[j*CNT_WIDTH +: CNT_WIDTH] = cnt[j];
        end
    end
endmodule
